uart_cmd_dispatch: RTL and testbench
====================================

// Module: uart_cmd_dispatch
// PURPOSE
//  Parametrised UART command dispatcher. Sits between the RX and TX byte engines.
//  - Decodes each received byte against a table of NUM_MODES command characters.
//  - Drives one-hot mode enables, e.g. breathing / flowing LED blocks.
//  - Queues one response byte per command and streams it to TX via a tx_en/tx_busy handshake.
// PARAMETERS
//  NUM_MODES       2         number of commands/modes (1..16)
//  CMD_CHARS       16'h4642  packed ASCII table; byte i = command of mode i ('B'=mode0, 'F'=mode1)
//  CASE_FOLD       1         1: letters match regardless of case (compare with bit5 cleared)
//  UNKNOWN_CLEARS  1         1: unknown byte deasserts all modes; 0: unknown byte keeps current mode
//  FIFO_DEPTH      4         response FIFO entries, power of 2, >=2
//  CNT_W           8         width of accepted-command counter
// PORTS
//  sys_clk      in   1          system clock, all logic rising-edge
//  rst          in   1          asynchronous reset, active-high
//  rx_valid     in   1          one-cycle strobe: rx_data holds a new byte
//  rx_data      in   8          received byte
//  tx_busy      in   1          TX engine busy (high from cycle after tx_en until stop bit done)
//  mode_en      out  NUM_MODES  one-hot mode enables, all-zero = idle
//  mode_idx     out  IDX_W      index of active mode; IDX_W = max(1,$clog2(NUM_MODES))
//  mode_active  out  1          |mode_en
//  tx_data      out  8          response byte to TX, stable while tx_en high
//  tx_en        out  1          one-cycle transmit request
//  resp_ovf     out  1          sticky: a response was dropped on full FIFO
//  cmd_cnt      out  CNT_W      matched commands, saturates at all-ones
// BEHAVIOUR
//  Reset values: mode_en=0, mode_idx=0, mode_active=0, tx_data=0, tx_en=0, resp_ovf=0, cmd_cnt=0.
//  Reset also empties the FIFO and sends the TX FSM to IDLE. Applies mid-frame as well; no partial tx_en.
//  Decode (rx_valid in cycle N, result registered at N+1):
//   - match = lowest i where byte equals CMD_CHARS[8i+:8] (folded if CASE_FOLD).
//   - On a match:
//     - mode_en is set to one-hot bit i and mode_idx to i.
//     - cmd_cnt is incremented (saturating).
//     - The table character (uppercase) is pushed as the response.
//   - On a miss, 8'h3F '?' is pushed:
//     - UNKNOWN_CLEARS=1: mode_en is cleared to 0.
//     - UNKNOWN_CLEARS=0: mode is held.
//   - CR (8'h0D) and LF (8'h0A) are ignored: no state change, no push.
//   - Re-sending the active command re-asserts the same mode (no glitch) and still pushes an ack.
//  Response FIFO:
//   - Push at N+1 and pop by TX FSM in the same cycle are both allowed.
//   - Full and no pop: the byte is dropped, resp_ovf is set and held until rst.
//   - Empty pop never occurs (FSM gates on ~empty).
//  TX FSM (states IDLE, LOAD, WAIT_HI, WAIT_LO):
//   - IDLE: if ~empty && ~tx_busy, pop, register tx_data, go to LOAD.
//   - LOAD: tx_en=1 for exactly one cycle, then go to WAIT_HI.
//   - WAIT_HI: wait for tx_busy=1, then go to WAIT_LO.
//   - WAIT_LO: wait for tx_busy=0, then go to IDLE.
//   - Earliest tx_en is N+3 after rx_valid. One byte in flight maximum.
//  Back-to-back rx_valid every cycle is accepted. Decode never stalls on TX.
// CONFIGURATION
//  UART_CMD_ECHO_EN defined:
//   - Response FIFO and TX FSM are present, as above.
//  UART_CMD_ECHO_EN undefined:
//   - No FIFO and no FSM.
//   - tx_en=0, tx_data=0, resp_ovf=0 constant; tx_busy is ignored.
//   - Decode, mode outputs and cmd_cnt are unchanged.
// STRUCTURE
//  Package uart_cmd_pkg:
//   - ASCII_NAK=8'h3F, ASCII_CR, ASCII_LF, CASE_MASK=8'hDF.
//   - Enum tx_state_t {IDLE,LOAD,WAIT_HI,WAIT_LO}.
//  Sub-module uart_resp_fifo:
//   - Synchronous FIFO with parameters WIDTH, DEPTH.
//   - Ports push, pop, din, dout, full, empty; async active-high rst.
//   - Instantiated only under UART_CMD_ECHO_EN.
//  Decode loop and TX FSM live in uart_cmd_dispatch.
// TESTING
//  1 Defaults, rx 'b' then 'F' -> mode_en 01 at N+1, then 10; mode_idx 0 then 1; tx bytes 'B','F'; cmd_cnt=2.
//  2 rx 'x' with mode 01 active -> mode_en=00, '?' transmitted. Same with UNKNOWN_CLEARS=0 -> mode_en stays 01.
//  3 rx 8'h0D, 8'h0A -> no output change, no tx_en.
//  4 tx_busy held high, 6 bytes 'B' back-to-back -> 4 queued, resp_ovf=1. After release, exactly 4 tx_en pulses of 'B'.
//  5 rst pulsed while in WAIT_LO with 2 bytes queued -> all outputs to reset values, no further tx_en.
//  6 NUM_MODES=4, CMD_CHARS="RGBW", CNT_W=2, 5 valid commands -> cmd_cnt=3 (saturated). Build without UART_CMD_ECHO_EN -> tx_en never asserts.

Source files
------------

// File: rtl/uart_cmd_pkg.sv
// rtl/uart_cmd_pkg.sv - shared constants, TX state enum and case-fold helper for the UART command dispatcher
package uart_cmd_pkg;

    localparam logic [7:0] ASCII_NAK = 8'h3F;
    localparam logic [7:0] ASCII_CR  = 8'h0D;
    localparam logic [7:0] ASCII_LF  = 8'h0A;
    localparam logic [7:0] CASE_MASK = 8'hDF;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT_HI,
        WAIT_LO
    } tx_state_t;

    // Clearing bit 5 maps lowercase ASCII letters onto their uppercase codes.
    function automatic logic [7:0] fold(input logic [7:0] c, input bit en);
        return en ? (c & CASE_MASK) : c;
    endfunction

endpackage

// File: rtl/uart_resp_fifo.sv
// rtl/uart_resp_fifo.sv - synchronous show-ahead FIFO; a push while full without a pop is discarded
module uart_resp_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             wr;
    logic             rd;

    // A simultaneous pop frees the slot, so a push on full is still accepted then.
    assign wr    = push && (!full || pop);
    assign rd    = pop && !empty;
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr) wr_ptr <= wr_ptr + 1'b1;
            if (rd) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/uart_cmd_dispatch.sv
// rtl/uart_cmd_dispatch.sv - UART command decoder driving one-hot mode enables; response echo path under UART_CMD_ECHO_EN
module uart_cmd_dispatch
    import uart_cmd_pkg::*;
#(
    parameter int                   NUM_MODES      = 2,
    parameter logic [8*NUM_MODES-1:0] CMD_CHARS    = 16'h4642,
    parameter int                   CASE_FOLD      = 1,
    parameter int                   UNKNOWN_CLEARS = 1,
    parameter int                   FIFO_DEPTH     = 4,
    parameter int                   CNT_W          = 8,
    localparam int                  IDX_W          = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1
) (
    input  logic                 sys_clk,
    input  logic                 rst,
    input  logic                 rx_valid,
    input  logic [7:0]           rx_data,
    input  logic                 tx_busy,
    output logic [NUM_MODES-1:0] mode_en,
    output logic [IDX_W-1:0]     mode_idx,
    output logic                 mode_active,
    output logic [7:0]           tx_data,
    output logic                 tx_en,
    output logic                 resp_ovf,
    output logic [CNT_W-1:0]     cmd_cnt
);

    logic             hit;
    logic [IDX_W-1:0] hit_idx;
    logic [7:0]       hit_char;
    logic             accept;

    // Descending scan so the lowest matching table entry wins.
    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        hit_char = ASCII_NAK;
        for (int i = NUM_MODES - 1; i >= 0; i--) begin
            if (fold(rx_data, CASE_FOLD != 0) == fold(CMD_CHARS[8*i +: 8], CASE_FOLD != 0)) begin
                hit      = 1'b1;
                hit_idx  = IDX_W'(i);
                hit_char = CMD_CHARS[8*i +: 8];
            end
        end
    end

    assign accept      = rx_valid && (rx_data != ASCII_CR) && (rx_data != ASCII_LF);
    assign mode_active = |mode_en;

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            mode_en  <= '0;
            mode_idx <= '0;
            cmd_cnt  <= '0;
        end else if (accept) begin
            if (hit) begin
                mode_en  <= NUM_MODES'(1) << hit_idx;
                mode_idx <= hit_idx;
                if (cmd_cnt != '1) cmd_cnt <= cmd_cnt + 1'b1;
            end else if (UNKNOWN_CLEARS != 0) begin
                mode_en <= '0;
            end
        end
    end

`ifdef UART_CMD_ECHO_EN
    logic      push_q;
    logic [7:0] push_data_q;
    logic      pop;
    logic      full;
    logic      empty;
    logic [7:0] fifo_dout;
    tx_state_t state;
    tx_state_t next_state;

    // Responses enter the FIFO one cycle after the mode outputs update.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            push_q      <= 1'b0;
            push_data_q <= '0;
        end else begin
            push_q      <= accept;
            push_data_q <= hit_char;
        end
    end

    uart_resp_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_resp_fifo (
        .clk   (sys_clk),
        .rst   (rst),
        .push  (push_q),
        .pop   (pop),
        .din   (push_data_q),
        .dout  (fifo_dout),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (!empty && !tx_busy) next_state = LOAD;
            LOAD:    next_state = WAIT_HI;
            WAIT_HI: if (tx_busy) next_state = WAIT_LO;
            WAIT_LO: if (!tx_busy) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        pop   = (state == IDLE) && !empty && !tx_busy;
        tx_en = (state == LOAD);
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            tx_data  <= '0;
            resp_ovf <= 1'b0;
        end else begin
            if (pop) tx_data <= fifo_dout;
            if (push_q && full && !pop) resp_ovf <= 1'b1;
        end
    end
`else
    logic [8:0] unused_sig;
    assign unused_sig = {tx_busy, hit_char};
    assign tx_en      = 1'b0;
    assign tx_data    = 8'h00;
    assign resp_ovf   = 1'b0;
`endif

endmodule

// File: tb/tb_uart_cmd_dispatch.sv
// tb/tb_uart_cmd_dispatch.sv - directed self-checking bench for uart_cmd_dispatch (default and UART_CMD_ECHO_EN builds)
module tb_uart_cmd_dispatch;

`ifdef UART_CMD_ECHO_EN
    localparam bit ECHO = 1'b1;
`else
    localparam bit ECHO = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid2 = 1'b0;
    logic [7:0] rx_data2 = 8'h00;
    logic       zero = 1'b0;
    logic       busy_hold = 1'b0;
    logic [3:0] busy_cnt = 4'd0;
    logic       tx_busy0;

    logic [1:0] mode_en0, mode_en1;
    logic       mode_idx0, mode_idx1;
    logic       mode_active0, mode_active1;
    logic [7:0] tx_data0, tx_data1;
    logic       tx_en0, tx_en1;
    logic       resp_ovf0, resp_ovf1;
    logic [7:0] cmd_cnt0, cmd_cnt1;

    logic [3:0] mode_en2;
    logic [1:0] mode_idx2;
    logic       mode_active2;
    logic [7:0] tx_data2;
    logic       tx_en2;
    logic       resp_ovf2;
    logic [1:0] cmd_cnt2;

    logic [7:0] log_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    uart_cmd_dispatch dut0 (
        .sys_clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .tx_busy(tx_busy0),
        .mode_en(mode_en0), .mode_idx(mode_idx0), .mode_active(mode_active0),
        .tx_data(tx_data0), .tx_en(tx_en0), .resp_ovf(resp_ovf0), .cmd_cnt(cmd_cnt0)
    );

    uart_cmd_dispatch #(.UNKNOWN_CLEARS(0)) dut1 (
        .sys_clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .tx_busy(zero),
        .mode_en(mode_en1), .mode_idx(mode_idx1), .mode_active(mode_active1),
        .tx_data(tx_data1), .tx_en(tx_en1), .resp_ovf(resp_ovf1), .cmd_cnt(cmd_cnt1)
    );

    uart_cmd_dispatch #(.NUM_MODES(4), .CMD_CHARS(32'h5742_4752), .CNT_W(2)) dut2 (
        .sys_clk(clk), .rst(rst), .rx_valid(rx_valid2), .rx_data(rx_data2), .tx_busy(zero),
        .mode_en(mode_en2), .mode_idx(mode_idx2), .mode_active(mode_active2),
        .tx_data(tx_data2), .tx_en(tx_en2), .resp_ovf(resp_ovf2), .cmd_cnt(cmd_cnt2)
    );

    // TX engine model: busy for 6 cycles starting the cycle after each tx_en.
    assign tx_busy0 = (busy_cnt != 4'd0) || busy_hold;
    always @(posedge clk) begin
        if (tx_en0) begin
            log_q.push_back(tx_data0);
            busy_cnt <= 4'd6;
        end else if (busy_cnt != 4'd0) begin
            busy_cnt <= busy_cnt - 4'd1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic put(input logic [7:0] b);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
    endtask

    task automatic idle();
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        put(b);
        idle();
    endtask

    task automatic send2(input logic [7:0] b);
        @(negedge clk);
        rx_valid2 = 1'b1;
        rx_data2  = b;
        @(negedge clk);
        rx_valid2 = 1'b0;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        wait_cyc(3);
        check("rst_mode_en", mode_en0, 0);
        check("rst_mode_idx", mode_idx0, 0);
        check("rst_mode_active", mode_active0, 0);
        check("rst_tx_data", tx_data0, 0);
        check("rst_tx_en", tx_en0, 0);
        check("rst_resp_ovf", resp_ovf0, 0);
        check("rst_cmd_cnt", cmd_cnt0, 0);
        rst = 1'b0;
        wait_cyc(2);

        // lowercase 'b' folds onto mode 0; ack 'B' reaches tx_en at N+3
        send("b");
        check("t1_mode_en_b", mode_en0, 2'b01);
        check("t1_mode_idx_b", mode_idx0, 0);
        check("t1_active_b", mode_active0, 1);
        check("t1_tx_en_n1", tx_en0, 0);
        wait_cyc(1);
        check("t1_tx_en_n2", tx_en0, 0);
        wait_cyc(1);
        check("t1_tx_en_n3", tx_en0, ECHO);
        check("t1_tx_data_n3", tx_data0, ECHO ? 8'h42 : 8'h00);
        wait_cyc(15);
        send("F");
        check("t1_mode_en_f", mode_en0, 2'b10);
        check("t1_mode_idx_f", mode_idx0, 1);
        wait_cyc(15);
        check("t1_tx_count", log_q.size(), ECHO ? 2 : 0);
        for (int i = 0; i < log_q.size(); i++)
            check("t1_tx_byte", log_q[i], (i == 0) ? 8'h42 : 8'h46);
        check("t1_cmd_cnt", cmd_cnt0, 2);

        send("b");
        wait_cyc(15);
        log_q.delete();
        send("x");
        check("t2_mode_en_clear", mode_en0, 2'b00);
        check("t2_active_clear", mode_active0, 0);
        check("t2_mode_en_hold", mode_en1, 2'b01);
        check("t2_cmd_cnt", cmd_cnt0, 3);
        wait_cyc(15);
        check("t2_tx_count", log_q.size(), ECHO ? 1 : 0);
        if (log_q.size() > 0) check("t2_tx_nak", log_q[0], 8'h3F);

        send("F");
        wait_cyc(15);
        log_q.delete();
        send(8'h0D);
        send(8'h0A);
        check("t3_mode_en", mode_en0, 2'b10);
        check("t3_mode_idx", mode_idx0, 1);
        check("t3_cmd_cnt", cmd_cnt0, 4);
        wait_cyc(15);
        check("t3_tx_count", log_q.size(), 0);

        // six acks against a four-entry FIFO while TX is held busy
        busy_hold = 1'b1;
        log_q.delete();
        for (int i = 0; i < 6; i++) put("B");
        idle();
        wait_cyc(5);
        check("t4_resp_ovf", resp_ovf0, ECHO);
        check("t4_tx_held", log_q.size(), 0);
        check("t4_cmd_cnt", cmd_cnt0, 10);
        busy_hold = 1'b0;
        wait_cyc(80);
        check("t4_tx_count", log_q.size(), ECHO ? 4 : 0);
        for (int i = 0; i < log_q.size(); i++) check("t4_tx_byte", log_q[i], 8'h42);
        check("t4_resp_ovf_sticky", resp_ovf0, ECHO);

        // reset lands while the first byte is in WAIT_LO and two more are queued
        put("B");
        put("F");
        put("b");
        idle();
        check("t5_tx_en_inflight", tx_en0, ECHO);
        wait_cyc(3);
        rst = 1'b1;
        #1;
        check("t5_mode_en", mode_en0, 0);
        check("t5_mode_idx", mode_idx0, 0);
        check("t5_mode_active", mode_active0, 0);
        check("t5_tx_en", tx_en0, 0);
        check("t5_tx_data", tx_data0, 0);
        check("t5_resp_ovf", resp_ovf0, 0);
        check("t5_cmd_cnt", cmd_cnt0, 0);
        log_q.delete();
        wait_cyc(1);
        rst = 1'b0;
        wait_cyc(40);
        check("t5_no_tx_after_rst", log_q.size(), 0);

        send2("R");
        check("t6_mode_en_r", mode_en2, 4'b0001);
        check("t6_cnt_1", cmd_cnt2, 1);
        send2("g");
        check("t6_mode_en_g", mode_en2, 4'b0010);
        check("t6_mode_idx_g", mode_idx2, 1);
        send2("B");
        check("t6_cnt_3", cmd_cnt2, 3);
        send2("w");
        check("t6_mode_en_w", mode_en2, 4'b1000);
        check("t6_mode_idx_w", mode_idx2, 3);
        check("t6_cnt_sat", cmd_cnt2, 3);
        send2("X");
        check("t6_mode_en_miss", mode_en2, 4'b0000);
        send2("R");
        check("t6_mode_en_r2", mode_en2, 4'b0001);
        check("t6_cnt_sat2", cmd_cnt2, 3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
